uart_mmr: RTL
=============

# uart_mmr

Memory-mapped 8N1 UART on the core's data bus, alongside the RAM, `Seg7` and video MMRs, and connected to the top-level `txd`/`rxd` pins. It claims three word addresses starting at `BASE`:

- a transmit-data register;
- a receive-data register;
- a status register.

Both directions are single-byte buffered. Bit timing comes from a fixed clocks-per-bit divider on `clk_core`.

## Interface
- `BASE`, default 32'h200: word address of the TX register. RX is at `BASE+1`, STATUS at `BASE+2`.
- `CLK_DIV`, default 217: `clk` cycles per bit (25 MHz / 115200). Must be ≥ 4.

Ports:
- `clk`  in  1: core clock; all logic sits on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `enable`  in  1: when low, bus accesses are ignored and `data` is released; serial engines keep running.
- `rw`  in  1: 1 means the core writes `data`; 0 means a read.
- `addr`  in  32: word address.
- `data`  inout  32: driven only during a decoded read, otherwise `'bz`.
- `rxd`  in  1: serial input; asynchronous, idle high.
- `txd`  out  1: serial output, idle high.

## Operation
- Decode: `hit = enable & (addr >= BASE) & (addr < BASE+3)`.
- Read drive (combinational): when `hit & !rw`, drive `data` as follows.
  - TX address: `{24'b0, tx_shadow}`.
  - RX address: `{24'b0, rx_data}`.
  - STATUS address: `{28'b0, frame_err, overrun, rx_valid, tx_busy}`.
- Write to TX with `tx_busy` = 0: on that edge, latch `data[7:0]`, set `tx_busy`, and enter TX START.
- Write to TX with `tx_busy` = 1: the write is dropped. No status bit is set.
- Writes to RX or STATUS are ignored.
- Read side effects are applied on the rising edge where the read is decoded. Each core read is one cycle.
  - RX read clears `rx_valid`.
  - STATUS read clears `overrun` and `frame_err`, but not `rx_valid`.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - `txd` is 0 in START, `shift[0]` in DATA (LSB first, 8 bits), and 1 in STOP and IDLE.
  - Every state other than IDLE lasts exactly `CLK_DIV` cycles.
  - `tx_busy` clears on the edge STOP → IDLE.
- RX front end: a 2-flop synchronizer on `rxd`.
- RX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a synchronized high-to-low transition enters START with the counter at 0.
  - START: at count `CLK_DIV/2 - 1`, resample. If the line is 1, it was a false start: return to IDLE with no flags set. If 0, enter DATA.
  - DATA: sample every `CLK_DIV` cycles, mid-bit. Shift in LSB first for 8 bits.
  - STOP: sample once, `CLK_DIV` later.
- Stop-bit result:
  - Stop bit = 1: load `rx_data` and set `rx_valid`. If `rx_valid` was already 1 on that edge, also set `overrun`; the new byte overwrites the old one.
  - Stop bit = 0: set `frame_err` and discard the byte (`rx_data` and `rx_valid` are unchanged).
- Simultaneous events (same edge):
  - RX completion and an RX read: completion wins, so `rx_valid` = 1 and `overrun` is not set.
  - Setting `overrun`/`frame_err` and a STATUS read: the set wins.
- Reset values:
  - `txd` = 1, `tx_busy` = 0, `tx_shadow` = 0.
  - `rx_valid` = 0, `overrun` = 0, `frame_err` = 0, `rx_data` = 0.
  - Both FSMs in IDLE. The synchronizer presets to 1, so reset does not produce a false start.
- Reset mid-frame: transmission aborts with `txd` high immediately (asynchronous). A partial RX frame is discarded.

## Timing
- TX write edge at cycle 0:
  - `txd` goes low after that edge.
  - Start bit occupies cycles 1..`CLK_DIV`.
  - Data bit *i* starts at cycle `1 + (i+1)·CLK_DIV`.
  - Stop bit ends, and `tx_busy` falls, at cycle `10·CLK_DIV`.
  - A back-to-back write accepted on that edge produces zero idle time between frames.
- RX: `rx_valid` rises 2 cycles of synchronizer latency plus `CLK_DIV/2 + 9·CLK_DIV` cycles after the `rxd` falling edge, ±1 cycle.
- Read data is valid in the same cycle as `addr`/`rw` (no wait state). Status reflects state as of the previous edge.
- Counter width is `$clog2(CLK_DIV)`. It wraps to 0 on each bit boundary.

## Test plan
- **TX frame.** `CLK_DIV`=8. Write 32'hA5 to `BASE`.
  - `txd` = 0, 1,0,1,0,0,1,0,1, 1, with each level held 8 cycles.
  - STATUS reads 1 during the frame and 0 at cycle 80.
- **TX busy drop.** Write 8'h11, then write 8'h22 at cycle 10.
  - Only 0x11 is transmitted.
  - TX readback returns 0x11.
- **RX loopback.** Tie `txd` to `rxd` and transmit 8'h3C.
  - STATUS = 4'b0010.
  - RX read returns 32'h3C.
  - The next STATUS read returns 0.
- **Overrun and framing.**
  - Drive two valid frames (0x01, 0x02) without reading: STATUS = 4'b0110 and RX = 0x02.
  - Drive a frame with stop bit = 0: `frame_err` is set and RX still reads 0x02.
- **Glitch and reset.**
  - A 2-cycle low pulse on `rxd` sets no flags and leaves `rx_valid` at 0.
  - Assert `reset` in TX bit 4: `txd` = 1 and STATUS = 0 immediately.
  - After release, a new write transmits normally.
- **Bus isolation.** With `enable`=0 or `addr` = `BASE+3`, `data` stays `z` and writes have no effect.

Source files
------------

// File: rtl/uart_mmr.sv
// uart_mmr: memory-mapped 8N1 UART with single-byte TX and RX buffers.
//
// Word map (relative to BASE):
//   +0 TX     write: start a frame if idle; read: last accepted byte
//   +1 RX     read: received byte, clears rx_valid
//   +2 STATUS read: {frame_err, overrun, rx_valid, tx_busy}, clears frame_err/overrun
//
// Ports:
//   clk     core clock, rising edge
//   reset   asynchronous active-high reset
//   enable  bus access qualifier
//   rw      1 = core writes data, 0 = core reads
//   addr    word address
//   data    bidirectional data bus, driven only during a decoded read
//   rxd     asynchronous serial input, idle high
//   txd     serial output, idle high
module uart_mmr #(
    parameter logic [31:0] BASE    = 32'h200,
    parameter int unsigned CLK_DIV = 217
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        rw,
    input  logic [31:0] addr,
    inout  wire  [31:0] data,
    input  logic        rxd,
    output logic        txd
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CntLast = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CntHalf = CW'(CLK_DIV / 2 - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    // ---------------------------------------------------------------- bus decode
    logic        hit, sel_tx, sel_rx, sel_st;
    logic        wr_tx, rd_rx, rd_st;
    logic [31:0] rdata;
    logic        tx_busy;

    assign hit    = enable && (addr >= BASE) && (addr < BASE + 32'd3);
    assign sel_tx = hit && (addr == BASE);
    assign sel_rx = hit && (addr == BASE + 32'd1);
    assign sel_st = hit && (addr == BASE + 32'd2);
    assign wr_tx  = sel_tx && rw;
    assign rd_rx  = sel_rx && !rw;
    assign rd_st  = sel_st && !rw;

    // ---------------------------------------------------------------- TX engine
    logic [1:0]    tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic [7:0]    tx_shadow_q, tx_shadow_d;
    logic          txd_q, txd_d;
    logic          tx_done, tx_accept;

    assign tx_busy = (tx_state_q != StIdle);
    assign tx_done = (tx_cnt_q == CntLast);
    // A write landing on the final stop-bit edge chains straight into the next frame.
    assign tx_accept = wr_tx && (!tx_busy || (tx_state_q == StStop && tx_done));

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_shadow_d = tx_shadow_q;
        case (tx_state_q)
            StStart: begin
                if (tx_done) begin
                    tx_state_d = StData;
                    tx_cnt_d   = '0;
                    tx_bit_d   = 3'd0;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            StData: begin
                if (tx_done) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = StStop;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            StStop: begin
                if (tx_done) begin
                    tx_state_d = StIdle;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
        if (tx_accept) begin
            tx_state_d  = StStart;
            tx_cnt_d    = '0;
            tx_shift_d  = data[7:0];
            tx_shadow_d = data[7:0];
        end
        // txd is registered from the next state so the pin never glitches.
        case (tx_state_d)
            StStart: txd_d = 1'b0;
            StData:  txd_d = tx_shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q  <= StIdle;
            tx_cnt_q    <= '0;
            tx_bit_q    <= 3'd0;
            tx_shift_q  <= 8'd0;
            tx_shadow_q <= 8'd0;
            txd_q       <= 1'b1;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_shadow_q <= tx_shadow_d;
            txd_q       <= txd_d;
        end
    end

    assign txd = txd_q;

    // ---------------------------------------------------------------- RX engine
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;
    logic          rx_done, rx_ok, rx_bad;

    assign rx_done = (rx_cnt_q == CntLast);

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        rx_ok       = 1'b0;
        rx_bad      = 1'b0;
        case (rx_state_q)
            StIdle: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = StStart;
                    rx_cnt_d   = '0;
                end
            end
            StStart: begin
                if (rx_cnt_q == CntHalf) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    // Line back high at mid start bit: a glitch, not a frame.
                    rx_state_d = rx_sync_q ? StIdle : StData;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            StData: begin
                if (rx_done) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = StStop;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: begin
                if (rx_done) begin
                    rx_state_d = StIdle;
                    rx_cnt_d   = '0;
                    rx_ok      = rx_sync_q;
                    rx_bad     = !rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
        endcase
        // Read-clears first so that same-edge flag sets take priority.
        if (rd_rx) begin
            rx_valid_d = 1'b0;
        end
        if (rd_st) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (rx_ok) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rd_rx) begin
                overrun_d = 1'b1;
            end
        end
        if (rx_bad) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= StIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= 3'd0;
            rx_shift_q  <= 8'd0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rxd;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ---------------------------------------------------------------- read mux
    always_comb begin
        rdata = 32'd0;
        if (sel_tx) begin
            rdata = {24'd0, tx_shadow_q};
        end else if (sel_rx) begin
            rdata = {24'd0, rx_data_q};
        end else if (sel_st) begin
            rdata = {28'd0, frame_err_q, overrun_q, rx_valid_q, tx_busy};
        end
    end

    assign data = (hit && !rw) ? rdata : {32{1'bz}};

endmodule
